ekf_stage_scheduler: RTL and testbench

//   Sequences the RSA systolic array through EKF-SLAM stages: predict (PRD), new-landmark init (NEW)
//   and observation update (UPD). Buffers host commands in a small FIFO and validates each one

---
 rtl/ekf_stage_scheduler_if.sv | 24 ++
 rtl/ekf_stage_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_ekf_stage_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ekf_stage_scheduler_if.sv
// Host command and RSA stage handshake bundle for the EKF stage scheduler.
// The slave modport is the scheduler's view; the master modport drives host and RSA sides.
interface ekf_stage_scheduler_if #(
  parameter int ROW_LEN = 10
);
  logic               cmd_val;
  logic               cmd_rdy;
  logic [1:0]         cmd_type;
  logic [ROW_LEN-1:0] cmd_lm_id;
  logic [2:0]         rsa_stage_val;
  logic [2:0]         rsa_stage_rdy;
  logic [2:0]         rsa_stage_done;
  logic [ROW_LEN-1:0] rsa_lm_id;

  modport slave (
    input  cmd_val, cmd_type, cmd_lm_id, rsa_stage_rdy, rsa_stage_done,
    output cmd_rdy, rsa_stage_val, rsa_lm_id
  );

  modport master (
    output cmd_val, cmd_type, cmd_lm_id, rsa_stage_rdy, rsa_stage_done,
    input  cmd_rdy, rsa_stage_val, rsa_lm_id
  );
endinterface

// File: rtl/ekf_stage_scheduler.sv
// EKF-SLAM stage scheduler: buffers host commands, validates them against the map size and
// sequences the RSA through PRD/NEW/UPD stages under a watchdog.
//   state  | meaning
//   IDLE   | pop and validate next command, honour clear_map
//   ISSUE  | rsa_stage_val asserted, waiting for matching rsa_stage_rdy
//   BUSY   | stage accepted, waiting for matching rsa_stage_done
//   ERR    | watchdog expired; FIFO frozen until err_clr
module ekf_stage_scheduler #(
  parameter int ROW_LEN      = 10,
  parameter int MAX_LANDMARK = 500,
  parameter int CMD_DEPTH    = 4,
  parameter int TIMEOUT_W    = 16
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  ekf_stage_scheduler_if.slave bus,
  output logic [ROW_LEN-1:0]   landmark_num,
  input  logic                 clear_map,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code,
  input  logic                 err_clr
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int ENT_W = ROW_LEN + 2;
  localparam logic [PTR_W:0]     DEPTH_C = (PTR_W+1)'(CMD_DEPTH);
  localparam logic [ROW_LEN-1:0] MAX_LM  = ROW_LEN'(MAX_LANDMARK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t               state_q;
  logic [ENT_W-1:0]     mem_q [CMD_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       cnt_q;
  logic [2:0]           stage_q;
  logic [2:0]           val_q;
  logic [ROW_LEN-1:0]   lm_id_q;
  logic [ROW_LEN-1:0]   lm_num_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 err_q;
  logic [1:0]           err_code_q;

  logic                 full, push, pop;
  logic [ENT_W-1:0]     head;
  logic [1:0]           head_type;
  logic [ROW_LEN-1:0]   head_id;
  logic                 bad;
  logic [1:0]           bad_code;
  logic [2:0]           stage_oh;
  logic [ROW_LEN-1:0]   lm_sel;
  logic [TIMEOUT_W-1:0] wd_nxt;
  logic                 wd_hit;

  assign full = (cnt_q == DEPTH_C);
  assign push = bus.cmd_val && !full;
  assign pop  = (state_q == S_IDLE) && !clear_map && (cnt_q != '0);

  assign head      = mem_q[rd_ptr_q];
  assign head_type = head[ENT_W-1:ROW_LEN];
  assign head_id   = head[ROW_LEN-1:0];

  always_comb begin
    bad      = 1'b0;
    bad_code = 2'd0;
    stage_oh = 3'b000;
    lm_sel   = '0;
    if (head_type == 2'd3) begin
      bad      = 1'b1;
      bad_code = 2'd3;
    end else if (head_type == 2'd1 && lm_num_q == MAX_LM) begin
      bad      = 1'b1;
      bad_code = 2'd1;
    end else if (head_type == 2'd2 && head_id >= lm_num_q) begin
      bad      = 1'b1;
      bad_code = 2'd2;
    end
    case (head_type)
      2'd0:    stage_oh = 3'b001;
      2'd1:    begin stage_oh = 3'b010; lm_sel = lm_num_q; end
      2'd2:    begin stage_oh = 3'b100; lm_sel = head_id;  end
      default: stage_oh = 3'b000;
    endcase
  end

  // The watchdog fires on the cycle the count would reach the limit, so a stage
  // stuck in ISSUE holds rsa_stage_val for exactly timeout_limit cycles.
  assign wd_nxt = wd_q + 1'b1;
  assign wd_hit = (timeout_limit != '0) && (wd_nxt == timeout_limit);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.cmd_type, bus.cmd_lm_id};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      val_q      <= '0;
      lm_id_q    <= '0;
      lm_num_q   <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      // A new error raised below overrides a simultaneous err_clr.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_map) begin
            lm_num_q <= '0;
          end else if (pop) begin
            if (bad) begin
              err_q      <= 1'b1;
              err_code_q <= bad_code;
            end else begin
              stage_q <= stage_oh;
              val_q   <= stage_oh;
              lm_id_q <= lm_sel;
              wd_q    <= '0;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wd_q <= wd_nxt;
          if (wd_hit) begin
            val_q      <= '0;
            err_q      <= 1'b1;
            err_code_q <= 2'd0;
            state_q    <= S_ERR;
          end else if ((bus.rsa_stage_rdy & stage_q) != 3'b000) begin
            val_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          wd_q <= wd_nxt;
          if (wd_hit) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd0;
            state_q    <= S_ERR;
          end else if ((bus.rsa_stage_done & stage_q) != 3'b000) begin
            if (stage_q[1]) lm_num_q <= lm_num_q + 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          if (err_clr) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_rdy       = !full;
  assign bus.rsa_stage_val = val_q;
  assign bus.rsa_lm_id     = lm_id_q;
  assign landmark_num      = lm_num_q;
  assign busy              = (state_q != S_IDLE) || (cnt_q != '0);
  assign err               = err_q;
  assign err_code          = err_code_q;

endmodule

// File: tb/tb_ekf_stage_scheduler.sv
// Scoreboard bench for ekf_stage_scheduler: a push-time model predicts each issued stage
// and landmark id; a negedge monitor compares them as the scheduler raises rsa_stage_val.
module tb_ekf_stage_scheduler;
  localparam int ROW_LEN = 10;
  localparam int MAX_LM  = 4;
  localparam int TW      = 16;

  logic               clk = 1'b0;
  logic               sys_rst_n;
  logic [ROW_LEN-1:0] landmark_num;
  logic               clear_map;
  logic [TW-1:0]      timeout_limit;
  logic               busy, err, err_clr;
  logic [1:0]         err_code;

  ekf_stage_scheduler_if #(.ROW_LEN(ROW_LEN)) bus ();

  ekf_stage_scheduler #(
    .ROW_LEN(ROW_LEN), .MAX_LANDMARK(MAX_LM), .CMD_DEPTH(4), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus), .landmark_num(landmark_num),
    .clear_map(clear_map), .timeout_limit(timeout_limit), .busy(busy),
    .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]         stage;
    logic [ROW_LEN-1:0] lm;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mdl_num = 0;
  logic mdl_err = 1'b0;
  logic [1:0] mdl_code = 2'd0;
  int   last_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the command is accepted.
  task automatic push_cmd(input logic [1:0] t, input logic [ROW_LEN-1:0] id);
    int n = 0;
    exp_t e;
    while (!bus.cmd_rdy && n < 50) begin @(negedge clk); n++; end
    check_eq("push_wait", 32'(n < 50), 1);
    bus.cmd_val = 1'b1; bus.cmd_type = t; bus.cmd_lm_id = id;
    @(negedge clk);
    bus.cmd_val = 1'b0;
    if (t == 2'd3) begin
      mdl_err = 1'b1; mdl_code = 2'd3;
    end else if (t == 2'd1 && mdl_num == MAX_LM) begin
      mdl_err = 1'b1; mdl_code = 2'd1;
    end else if (t == 2'd2 && int'(id) >= mdl_num) begin
      mdl_err = 1'b1; mdl_code = 2'd2;
    end else begin
      e.stage = 3'b001 << t;
      e.lm    = (t == 2'd2) ? id : (t == 2'd1) ? ROW_LEN'(mdl_num) : '0;
      exp_q.push_back(e);
      if (t == 2'd1) mdl_num++;
    end
  endtask

  task automatic serve(input int rdy_dly, input int done_dly);
    int n = 0;
    logic [2:0] s;
    while (bus.rsa_stage_val == 3'b000 && n < 50) begin @(negedge clk); n++; end
    check_eq("serve_wait", 32'(n < 50), 1);
    s = bus.rsa_stage_val;
    repeat (rdy_dly) @(negedge clk);
    bus.rsa_stage_rdy = s;
    @(negedge clk);
    bus.rsa_stage_rdy = 3'b000;
    repeat (done_dly - 1) @(negedge clk);
    bus.rsa_stage_done = s;
    @(negedge clk);
    bus.rsa_stage_done = 3'b000;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    mdl_err = 1'b0;
  endtask

  initial begin : monitor
    logic [2:0] prev;
    int run;
    exp_t e;
    prev = 3'b000;
    run  = 0;
    forever begin
      @(negedge clk);
      if (bus.rsa_stage_val != 3'b000 && prev == 3'b000) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(bus.rsa_stage_val), 0);
        else begin
          e = exp_q.pop_front();
          check_eq("sb_stage", 32'(bus.rsa_stage_val), 32'(e.stage));
          check_eq("sb_lm_id", 32'(bus.rsa_lm_id), 32'(e.lm));
        end
      end
      if (bus.rsa_stage_val != 3'b000) run++;
      else if (prev != 3'b000) begin last_run = run; run = 0; end
      prev = bus.rsa_stage_val;
    end
  end

  initial begin : guard
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int n;
    sys_rst_n = 1'b0; clear_map = 1'b0; timeout_limit = 16'd100; err_clr = 1'b0;
    bus.cmd_val = 1'b0; bus.cmd_type = 2'd0; bus.cmd_lm_id = '0;
    bus.rsa_stage_rdy = 3'b000; bus.rsa_stage_done = 3'b000;
    repeat (2) @(negedge clk);
    check_eq("rst_val", 32'(bus.rsa_stage_val), 0);
    check_eq("rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
    check_eq("rst_lm_num", 32'(landmark_num), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_err", 32'(err), 0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // PRD: latency, val held 3 cycles, busy drops after done
    push_cmd(2'd0, '0);
    check_eq("prd_lat0_val", 32'(bus.rsa_stage_val), 0);
    check_eq("prd_busy", 32'(busy), 1);
    @(negedge clk);
    check_eq("prd_lat1_val", 32'(bus.rsa_stage_val), 32'h1);
    serve(2, 5);
    check_eq("prd_val_cycles", 32'(last_run), 3);
    check_eq("prd_busy_after", 32'(busy), 0);

    // 3x NEW back-to-back
    for (int i = 0; i < 3; i++) push_cmd(2'd1, '0);
    for (int i = 0; i < 3; i++) begin
      serve(0, 1);
      check_eq("new_lm_num", 32'(landmark_num), 32'(i + 1));
    end

    // Map full: fourth NEW fills the map, fifth is rejected
    push_cmd(2'd1, '0);
    push_cmd(2'd1, '0);
    serve(0, 1);
    repeat (3) @(negedge clk);
    check_eq("full_err", 32'(err), 32'(mdl_err));
    check_eq("full_code", 32'(err_code), 32'(mdl_code));
    check_eq("full_lm_num", 32'(landmark_num), 32'(mdl_num));
    check_eq("full_busy", 32'(busy), 0);
    pulse_err_clr();
    check_eq("full_err_clr", 32'(err), 0);

    // clear_map then UPD bad id / good id
    clear_map = 1'b1;
    @(negedge clk);
    clear_map = 1'b0;
    mdl_num = 0;
    check_eq("clr_lm_num", 32'(landmark_num), 0);
    push_cmd(2'd1, '0);
    push_cmd(2'd1, '0);
    serve(0, 1);
    serve(0, 1);
    check_eq("upd_lm_num", 32'(landmark_num), 2);
    push_cmd(2'd2, 10'd2);
    push_cmd(2'd2, 10'd1);
    serve(0, 1);
    check_eq("upd_err", 32'(err), 32'(mdl_err));
    check_eq("upd_code", 32'(err_code), 32'(mdl_code));
    check_eq("upd_lm_num_kept", 32'(landmark_num), 2);
    pulse_err_clr();

    // Watchdog: stage never accepted
    timeout_limit = 16'd8;
    push_cmd(2'd0, '0);
    push_cmd(2'd0, '0);
    check_eq("wd_val_start", 32'(bus.rsa_stage_val), 32'h1);
    n = 0;
    while (bus.rsa_stage_val != 3'b000 && n < 40) begin @(negedge clk); n++; end
    mdl_err = 1'b1; mdl_code = 2'd0;
    check_eq("wd_cycles", 32'(n), 8);
    check_eq("wd_err", 32'(err), 32'(mdl_err));
    check_eq("wd_code", 32'(err_code), 32'(mdl_code));
    push_cmd(2'd0, '0);
    repeat (3) @(negedge clk);
    check_eq("err_no_issue", 32'(bus.rsa_stage_val), 0);
    check_eq("err_busy", 32'(busy), 1);
    check_eq("err_lm_num", 32'(landmark_num), 2);
    timeout_limit = 16'd100;
    pulse_err_clr();
    check_eq("err_cleared", 32'(err), 0);
    serve(0, 1);
    serve(0, 1);
    check_eq("wd_after_busy", 32'(busy), 0);

    // FIFO full while BUSY, then reset mid-stage
    timeout_limit = 16'd0;
    push_cmd(2'd0, '0);
    n = 0;
    while (bus.rsa_stage_val == 3'b000 && n < 20) begin @(negedge clk); n++; end
    bus.rsa_stage_rdy = bus.rsa_stage_val;
    @(negedge clk);
    bus.rsa_stage_rdy = 3'b000;
    for (int i = 0; i < 4; i++) push_cmd(2'd0, '0);
    check_eq("fifo_full_rdy", 32'(bus.cmd_rdy), 0);
    bus.cmd_val = 1'b1; bus.cmd_type = 2'd0;
    repeat (3) @(negedge clk);
    check_eq("fifo_held_rdy", 32'(bus.cmd_rdy), 0);
    check_eq("fifo_held_busy", 32'(busy), 1);
    sys_rst_n = 1'b0;
    bus.cmd_val = 1'b0;
    #2;
    exp_q.delete();
    mdl_num = 0; mdl_err = 1'b0;
    check_eq("mrst_val", 32'(bus.rsa_stage_val), 0);
    check_eq("mrst_lm_num", 32'(landmark_num), 0);
    check_eq("mrst_cmd_rdy", 32'(bus.cmd_rdy), 1);
    check_eq("mrst_busy", 32'(busy), 0);
    check_eq("mrst_lm_id", 32'(bus.rsa_lm_id), 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    timeout_limit = 16'd100;
    @(negedge clk);
    push_cmd(2'd1, '0);
    serve(0, 1);
    check_eq("post_rst_lm_num", 32'(landmark_num), 1);
    repeat (3) @(negedge clk);
    check_eq("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
